muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle, parametrised multiply/divide unit for the processor datapath, the sequential successor to the single-cycle ALU's special operations. It adds signed/unsigned division with remainder, fixes divide-by-zero and signed-overflow behaviour, and produces ALU-compatible flags. It computes one bit per cycle (shift-add multiply, restoring divide) on operand magnitudes, then applies sign correction. The control unit stalls on `busy` and writes back on `done`.

## Interface
- WIDTH, 32, operand/result width (≥ 4).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled on a clk edge while not busy.
- op  in  3  000 UDIV, 001 SDIV, 101 MUL, 110 SMUL, 111 UMUL; other codes illegal.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid.
- Result  out  WIDTH  MUL low product, SMUL/UMUL low half, DIV quotient.
- Long  out  WIDTH  SMUL/UMUL high half, DIV remainder, 0 for MUL.
- ALUFlags  out  4  {N, Z, C, V}; updated with done.
- divzero  out  1  last completed op was a divide with b == 0.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with legal op latches op, |a|, |b| (signed ops only), and result signs.
  - Clears the accumulator and bit counter, then goes to CALC.
- CALC: WIDTH iterations, one per cycle, counter WIDTH-1 down to 0.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper half of a 2·WIDTH accumulator; then shift right.
  - Divide: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor; if non-negative, keep the difference and set the quotient bit to 1.
  - After the last iteration, go to FIX.
- FIX: applies sign correction, registers Result/Long/ALUFlags/divzero, pulses done, returns to IDLE.
- Signed rules:
  - SMUL negates the 2·WIDTH product when sign(a) ≠ sign(b).
  - SDIV truncates toward zero. The quotient is negated when signs differ. The remainder takes the sign of a.
- Divide by zero (UDIV/SDIV, b == 0): normal latency, Result = 0, Long = a, divzero = 1, V = 0.
- SDIV overflow (a = most negative, b = −1): Result = a, Long = 0, V = 1.
- Flags:
  - N = MSB of Result (MUL/DIV), or MSB of Long (SMUL/UMUL).
  - Z = 1 iff Result == 0 (MUL/DIV), or iff {Long, Result} == 0 (SMUL/UMUL).
  - C = 0 always.
  - V = 0 except SDIV overflow.
- Illegal op with start: no CALC. FIX occurs next cycle with Result = Long = 0, flags {0,1,0,0}, divzero = 0.
- Outputs hold their values between done pulses.

## Timing
- Reset values: busy = 0, done = 0, Result = 0, Long = 0, ALUFlags = 0, divzero = 0, state IDLE.
- Reset mid-operation aborts immediately. No done is produced for the aborted op.
- start accepted at edge E0 → busy = 1 after E0. CALC occupies edges E1..E_WIDTH. FIX is the state after E_WIDTH.
- done = 1 and busy = 0 after edge E_(WIDTH+1). Total latency is WIDTH+1 edges; 33 for WIDTH = 32.
- Illegal op: done after E1.
- start while busy: ignored, no queuing. a/b/op may change freely after E0.
- start high in the done cycle is accepted (back-to-back, no idle gap).
- done is exactly one cycle wide. Results are valid from the done cycle until the next done.

## Test plan
- Reset, then MUL a = 7, b = 6 → Result = 42, Long = 0, ALUFlags = 0000, done exactly 33 edges after the start edge; busy high for 33 cycles.
- SMUL a = 0xFFFFFFFE, b = 3 → Long = 0xFFFFFFFF, Result = 0xFFFFFFFA, N = 1. UMUL a = b = 0xFFFFFFFF → Long = 0xFFFFFFFE, Result = 0x00000001.
- SDIV a = −7 (0xFFFFFFF9), b = 2 → Result = 0xFFFFFFFD, Long = 0xFFFFFFFF, N = 1. UDIV 100 / 7 → Result = 14, Long = 2.
- UDIV 100 / 0 → Result = 0, Long = 100, divzero = 1, Z = 1. SDIV 0x80000000 / 0xFFFFFFFF → Result = 0x80000000, Long = 0, V = 1, N = 1.
- Pulse start with new operands mid-CALC → ignored, and the original result is returned. Start held in the done cycle → second op completes 33 edges later.
- Assert reset at CALC iteration 10 → busy, done, and all outputs go to 0 at once. Next op after release completes correctly. Illegal op 010 → done after 1 edge, flags 0100.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide: shift-add multiply and restoring divide on magnitudes, sign fix in FIX.
// Latency WIDTH+1 edges (illegal op: 1); start is ignored while busy, with no queuing.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Long,
   output logic [3:0]       ALUFlags,
   output logic             divzero
);
   localparam logic [2:0] OP_UDIV = 3'b000;
   localparam logic [2:0] OP_SDIV = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_SMUL = 3'b110;
   localparam logic [2:0] OP_UMUL = 3'b111;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               neg_q;
   logic               neg_rem;
   logic               bzero;
   logic               ovf;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic               op_legal;
   logic               op_signed;
   logic               op_div;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   always_comb begin
      op_legal  = op inside {OP_UDIV, OP_SDIV, OP_MUL, OP_SMUL, OP_UMUL};
      op_signed = (op == OP_SDIV) || (op == OP_SMUL);
      op_div    = (op == OP_UDIV) || (op == OP_SDIV);
      abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
      abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;
   end

   // Multiply keeps the multiplier in acc's low half; divide keeps {remainder, dividend/quotient}.
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_next;

   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      div_diff = rem_sh - {1'b0, mag_b};
      if ((op_q == OP_UDIV) || (op_q == OP_SDIV)) begin
         if (div_diff[WIDTH])
            acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fix_res;
   logic [WIDTH-1:0]   fix_long;
   logic               fix_n;
   logic               fix_z;
   logic               fix_v;
   logic               fix_dz;

   always_comb begin
      prod     = neg_q ? -acc : acc;
      quo      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem      = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_res  = '0;
      fix_long = '0;
      fix_v    = 1'b0;
      fix_dz   = 1'b0;
      case (op_q)
         OP_UDIV, OP_SDIV: begin
            if (bzero) begin
               // Long returns the original dividend; re-signing |a| recovers it.
               fix_long = neg_rem ? -mag_a : mag_a;
               fix_dz   = 1'b1;
            end else begin
               fix_res  = quo;
               fix_long = rem;
               fix_v    = ovf;
            end
         end
         OP_MUL: fix_res = acc[WIDTH-1:0];
         OP_SMUL, OP_UMUL: begin
            fix_res  = prod[WIDTH-1:0];
            fix_long = prod[2*WIDTH-1:WIDTH];
         end
         default: ;
      endcase
      if ((op_q == OP_SMUL) || (op_q == OP_UMUL)) begin
         fix_n = fix_long[WIDTH-1];
         fix_z = ({fix_long, fix_res} == '0);
      end else begin
         fix_n = fix_res[WIDTH-1];
         fix_z = (fix_res == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         neg_q    <= 1'b0;
         neg_rem  <= 1'b0;
         bzero    <= 1'b0;
         ovf      <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         Result   <= '0;
         Long     <= '0;
         ALUFlags <= '0;
         divzero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  mag_a   <= abs_a;
                  mag_b   <= abs_b;
                  neg_q   <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem <= op_signed && a[WIDTH-1];
                  bzero   <= (b == '0);
                  ovf     <= (op == OP_SDIV) && (a == MIN_NEG) && (b == '1);
                  acc     <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                  cnt     <= CNT_TOP;
                  busy    <= 1'b1;
                  state   <= op_legal ? CALC : FIX;
               end
            end
            CALC: begin
               acc <= acc_next;
               cnt <= cnt - CW'(1);
               if (cnt == '0)
                  state <= FIX;
            end
            FIX: begin
               Result   <= fix_res;
               Long     <= fix_long;
               ALUFlags <= {fix_n, fix_z, 1'b0, fix_v};
               divzero  <= fix_dz;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] Result;
   logic [W-1:0] Long;
   logic [3:0]   ALUFlags;
   logic         divzero;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .Result(Result), .Long(Long),
      .ALUFlags(ALUFlags), .divzero(divzero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] lng;
      logic [3:0]   fl;
      logic         dz;
   } exp_t;

   typedef struct {
      exp_t e;
      int   acc;
      int   due;
   } ent_t;

   ent_t q[$];
   ent_t cur;
   exp_t last = '0;
   logic busy_exp;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic logic is_legal(input logic [2:0] o);
      return o inside {3'b000, 3'b001, 3'b101, 3'b110, 3'b111};
   endfunction

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t                e;
      logic [63:0]         p;
      logic signed [63:0]  sp;
      int                  sx;
      int                  sy;
      e  = '0;
      sx = $signed(x);
      sy = $signed(y);
      case (o)
         3'b101: begin p = {32'b0, x} * {32'b0, y}; e.res = p[31:0]; end
         3'b111: begin p = {32'b0, x} * {32'b0, y}; e.res = p[31:0]; e.lng = p[63:32]; end
         3'b110: begin
            sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            e.res = sp[31:0];
            e.lng = sp[63:32];
         end
         3'b000: begin
            if (y == 0) begin e.lng = x; e.dz = 1'b1; end
            else begin e.res = x / y; e.lng = x % y; end
         end
         3'b001: begin
            if (y == 0) begin e.lng = x; e.dz = 1'b1; end
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin e.res = x; e.fl[0] = 1'b1; end
            else begin e.res = 32'(sx / sy); e.lng = 32'(sx % sy); end
         end
         default: begin e.fl = 4'b0100; return e; end
      endcase
      if (o == 3'b110 || o == 3'b111) begin
         e.fl[3] = e.lng[31];
         e.fl[2] = ({e.lng, e.res} == 64'd0);
      end else begin
         e.fl[3] = e.res[31];
         e.fl[2] = (e.res == 0);
      end
      return e;
   endfunction

   // Single compare process: busy every cycle, result on done, held outputs otherwise.
   always @(negedge clk) begin
      if (!reset) begin
         busy_exp = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].due);
         chk("busy", busy, busy_exp);
         if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", done, 1'b0);
            end else begin
               cur = q.pop_front();
               chk("latency", cyc, cur.due);
               last = cur.e;
            end
         end else if (q.size() > 0 && cyc >= q[0].due) begin
            chk("done_missing", done, 1'b1);
            cur = q.pop_front();
         end
         chk("result", Result, last.res);
         chk("long", Long, last.lng);
         chk("flags", ALUFlags, last.fl);
         chk("divzero", divzero, last.dz);
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      ent_t n;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      n.e   = model(o, x, y);
      n.acc = cyc + 1;
      n.due = cyc + 1 + (is_legal(o) ? 33 : 1);
      q.push_back(n);
      @(negedge clk); #1;
      start = 1'b0;
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("timeout", q.size(), 0);
         q.delete();
      end
   endtask

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [2:0] op_tab [6] = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b111, 3'b010};

   initial begin
      #1_000_000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1);
   end

   initial begin
      logic [2:0]   ro;
      logic [W-1:0] rx;
      logic [W-1:0] ry;

      // Hand-computed anchors for the model.
      chk("pin_mul",   model(3'b101, 32'd7, 32'd6), {32'd42, 32'd0, 4'b0000, 1'b0});
      chk("pin_smul",  model(3'b110, 32'hFFFF_FFFE, 32'd3), {32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000, 1'b0});
      chk("pin_umul",  model(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {32'h1, 32'hFFFF_FFFE, 4'b1000, 1'b0});
      chk("pin_sdiv",  model(3'b001, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000, 1'b0});
      chk("pin_udiv",  model(3'b000, 32'd100, 32'd7), {32'd14, 32'd2, 4'b0000, 1'b0});
      chk("pin_dz",    model(3'b000, 32'd100, 32'd0), {32'd0, 32'd100, 4'b0100, 1'b1});
      chk("pin_ovf",   model(3'b001, 32'h8000_0000, 32'hFFFF_FFFF), {32'h8000_0000, 32'd0, 4'b1001, 1'b0});
      chk("pin_illeg", model(3'b010, 32'd5, 32'd9), {32'd0, 32'd0, 4'b0100, 1'b0});

      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", {busy, done, Result, Long, ALUFlags, divzero}, '0);
      reset = 1'b0;
      @(negedge clk); #1;

      issue(3'b101, 32'd7, 32'd6);                   wait_idle();
      issue(3'b110, 32'hFFFF_FFFE, 32'd3);           wait_idle();
      issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_idle();
      issue(3'b001, 32'hFFFF_FFF9, 32'd2);           wait_idle();
      issue(3'b000, 32'd100, 32'd7);                 wait_idle();
      issue(3'b000, 32'd100, 32'd0);                 wait_idle();
      issue(3'b001, 32'h8000_0000, 32'hFFFF_FFFF);   wait_idle();
      issue(3'b010, 32'd5, 32'd9);                   wait_idle();

      // A start pulse mid-CALC must be dropped.
      issue(3'b000, 32'd1000, 32'd3);
      repeat (5) begin @(negedge clk); #1; end
      start = 1'b1; op = 3'b111; a = 32'd12345; b = 32'd678;
      @(negedge clk); #1;
      start = 1'b0;
      wait_idle();

      // Back-to-back: start presented in the done cycle.
      issue(3'b101, 32'd123, 32'd456);
      repeat (33) begin @(negedge clk); #1; end
      chk("b2b_done", done, 1'b1);
      issue(3'b110, 32'hFFFF_0001, 32'h0001_0003);
      wait_idle();

      // Reset around CALC iteration 10 aborts with no done.
      issue(3'b111, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (10) begin @(negedge clk); #1; end
      reset = 1'b1;
      #1;
      chk("abort_state", {busy, done, Result, Long, ALUFlags, divzero}, '0);
      q.delete();
      last = '0;
      repeat (2) begin @(negedge clk); #1; end
      reset = 1'b0;
      @(negedge clk); #1;
      issue(3'b001, 32'hFFFF_FF00, 32'd7);           wait_idle();

      for (int i = 0; i < 60; i++) begin
         ro = op_tab[$urandom_range(0, 5)];
         rx = pick_val();
         ry = pick_val();
         if ($urandom_range(0, 9) == 0) begin
            ro = 3'b001; rx = 32'h8000_0000; ry = 32'hFFFF_FFFF;
         end
         repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
         issue(ro, rx, ry);
         wait_idle();
      end

      repeat (3) begin @(negedge clk); #1; end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
